// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative RV32M multiply/divide unit (32-step shift-add / restoring divide)
// Optional MDU_FAST_MUL_EN: single-cycle combinational multiplier for MUL/MULH/MULHSU/MULHU.
module mul_div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FINISH, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        funct3_q, funct3_d;
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              is_div, a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              div_zero, div_ovf;
    logic [XLEN-1:0]   special_res;
    logic              neg_new;

    always_comb begin
        is_div   = funct3[2];
        a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                   (funct3 == 3'b100) || (funct3 == 3'b110);
        b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        a_neg    = a_signed && op_a[XLEN-1];
        b_neg    = b_signed && op_b[XLEN-1];
        a_mag    = a_neg ? -op_a : op_a;
        b_mag    = b_neg ? -op_b : op_b;
        div_zero = is_div && (op_b == '0);
        div_ovf  = is_div && !funct3[0] && (op_a == MIN_NEG) && (op_b == '1);
        if (div_zero) begin
            special_res = funct3[1] ? op_a : '1;
        end else begin
            special_res = funct3[1] ? '0 : MIN_NEG;
        end
        // Remainder follows the dividend's sign; quotient and MULH* follow sign mismatch.
        case (funct3)
            3'b001, 3'b100: neg_new = a_neg ^ b_neg;
            3'b010, 3'b110: neg_new = a_neg;
            default:        neg_new = 1'b0;
        endcase
    end

    logic [XLEN:0]     mul_sum, div_trial, div_diff;
    logic              div_ge;
    logic [2*XLEN-1:0] mul_step, div_step;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_step  = {mul_sum, acc_q[XLEN-1:1]};
        div_trial = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff  = div_trial - {1'b0, opnd_q};
        // Partial remainder is always below the divisor, so the top bit is a pure borrow.
        div_ge    = ~div_diff[XLEN];
        div_step  = {div_ge ? div_diff[XLEN-1:0] : div_trial[XLEN-1:0],
                     acc_q[XLEN-2:0], div_ge};
    end

    logic [2*XLEN-1:0] prod_signed;
    logic [XLEN-1:0]   div_val, finish_res;

    always_comb begin
        prod_signed = neg_q ? -acc_q : acc_q;
        div_val     = funct3_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
        if (funct3_q[2]) begin
            finish_res = neg_q ? -div_val : div_val;
        end else if (funct3_q[1:0] == 2'b00) begin
            finish_res = prod_signed[XLEN-1:0];
        end else begin
            finish_res = prod_signed[2*XLEN-1:XLEN];
        end
    end

`ifdef MDU_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_a, fast_b, fast_prod;
    logic [XLEN-1:0]   fast_res;

    always_comb begin
        fast_a    = {{XLEN{a_signed & op_a[XLEN-1]}}, op_a};
        fast_b    = {{XLEN{b_signed & op_b[XLEN-1]}}, op_b};
        fast_prod = fast_a * fast_b;
        fast_res  = (funct3[1:0] == 2'b00) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
    end
`endif

    always_comb begin
        state_d  = state_q;
        funct3_d = funct3_q;
        neg_d    = neg_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    funct3_d = funct3;
                    neg_d    = neg_new;
                    if (div_zero || div_ovf) begin
                        state_d  = S_DONE;
                        result_d = special_res;
`ifdef MDU_FAST_MUL_EN
                    end else if (!is_div) begin
                        state_d  = S_DONE;
                        result_d = fast_res;
`endif
                    end else begin
                        state_d = S_CALC;
                        cnt_d   = CW'(XLEN);
                        acc_d   = {{XLEN{1'b0}}, is_div ? a_mag : b_mag};
                        opnd_d  = is_div ? b_mag : a_mag;
                    end
                end
            end
            S_CALC: begin
                acc_d = funct3_q[2] ? div_step : mul_step;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                result_d = finish_res;
                state_d  = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            funct3_q <= '0;
            neg_q    <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            funct3_q <= funct3_d;
            neg_q    <= neg_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q == S_CALC) || (state_q == S_FINISH);
    assign done   = (state_q == S_DONE);
    assign result = result_q;

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative RV32M multiply/divide execution unit, directly downstream of the register file.
- Consumes the two register read operands (rs1/rs2 data) and produces a 32-bit result that the writeback path routes to the register file write port.
- The core stalls on busy until done pulses; writeback is enabled on done.

Parameters:
XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
clk  input  1  clock; all state updates on the rising edge
rstn  input  1  reset, asynchronous, active-low
start  input  1  request a new operation; sampled only when busy=0
funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
op_a  input  XLEN  rs1 operand (dividend / multiplicand)
op_b  input  XLEN  rs2 operand (divisor / multiplier)
busy  output  1  operation in progress; start ignored while high
done  output  1  one-cycle pulse: result valid this cycle
result  output  XLEN  operation result; held from done until next accepted start

Behaviour:
- Reset (rstn low, asynchronous): state=IDLE; busy=0, done=0, result=0; internal operand, accumulator and counter registers cleared. Reset mid-operation aborts it with no done pulse.
- States:
  - IDLE: busy=0. start=1 latches funct3/op_a/op_b.
    - Special case present: go to DONE.
    - Otherwise: go to CALC with counter=XLEN.
  - CALC: busy=1. One shift-add (multiply) or one restoring shift-subtract (divide) step per cycle; counter decrements. At counter==1, the final step is taken and the state goes to FINISH.
  - FINISH: busy=1. Sign correction applied; result registered. Go to DONE.
  - DONE: busy=0, done=1 for exactly one cycle. Go to IDLE. A start presented during DONE is accepted, with the same behaviour as in IDLE.
- Latency, start edge = cycle 0:
  - Normal ops: CALC occupies cycles 1..32, FINISH is cycle 33, done=1 in cycle 34.
  - Special-case ops: done=1 in cycle 1.
- Operand handling:
  - Signed ops (MULH, DIV, REM, and op_a of MULHSU) take magnitudes first and record the sign.
  - Multiply forms a 2*XLEN unsigned product.
    - Negated when the operand signs differ (MULH, MULHSU).
    - MUL returns product[31:0]; MULH, MULHSU and MULHU return product[63:32].
  - Divide is restoring division on magnitudes.
    - Quotient is negated when the signs differ (DIV).
    - Remainder takes the dividend's sign (REM).
- Special cases, no iteration:
  - Divide by zero (op_b==0): DIV/DIVU give 0xFFFFFFFF; REM/REMU give op_a.
  - Signed overflow (op_a==0x80000000, op_b==0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
  - Multiply by zero is not a special case; it takes the full latency.
- start while busy=1 is ignored; the latched operands are unaffected by input changes after acceptance.
- result changes only on the FINISH-to-DONE transition, the special-case path, or reset.

Optional Feature:
MDU_FAST_MUL_EN
- Defined: all four multiply ops use a single-cycle combinational XLEN x XLEN multiplier. The start edge goes IDLE to DONE directly, with done in cycle 1. Divide is unchanged.
- Undefined: multiplies use the iterative CALC/FINISH path with 34-cycle latency. No hardware multiplier is inferred.

Test Plan:
- Reset then idle: rstn low 3 cycles, release -> busy=0, done=0, result=0x00000000; no done pulse for 50 cycles without start.
- MUL/MULH: op_a=0xFFFFFFFE (-2), op_b=0x00000003.
  - MUL -> result=0xFFFFFFFA.
  - MULH -> result=0xFFFFFFFF.
  - MULHU -> result=0x00000002.
  - Latency: done at cycle 34, or cycle 1 with MDU_FAST_MUL_EN.
- DIV/REM signed: op_a=0xFFFFFFF9 (-7), op_b=2.
  - DIV -> 0xFFFFFFFD (-3).
  - REM -> 0xFFFFFFFF (-1).
  - DIVU -> 0x7FFFFFFC.
  - done at cycle 34; busy high cycles 1..33.
- Special cases:
  - DIVU 5/0 -> 0xFFFFFFFF.
  - REM 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
  - REM same operands -> 0.
  - All four: done in cycle 1.
- Protocol: start pulses with new operands during busy are ignored and do not affect the result; back-to-back start asserted in the DONE cycle is accepted.
- Reset mid-operation: rstn low at cycle 10 of a DIV -> busy=0, result=0, no done pulse. A fresh start after release yields the correct result.
